// File: rtl/acc_pkg.sv
// acc_pkg: hold-FSM state type and default sizing constants for acc_time_ctrl_mc
package acc_pkg;
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} hold_state_e;
    localparam int CH_NUM_DEF = 4;
    localparam int ADDR_W_DEF = 18;
    localparam int HOLD_W_DEF = 16;
endpackage

// File: rtl/acc_hold_stretch.sv
// acc_hold_stretch: per-channel hold FSM; extends a flag for hold_len count events after its falling edge
module acc_hold_stretch
    import acc_pkg::*;
#(
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fall,
    input  logic              cnt_ev,
    input  logic [HOLD_W-1:0] hold_len,
    output logic              hold
);
    hold_state_e       state, state_n;
    logic [HOLD_W-1:0] cnt, cnt_n, last;

    assign last = hold_len - HOLD_W'(1);
    assign hold = state == HOLD;

    // state and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // zero length wins, then (re)trigger on a fall, then count down the hold; a shrunk length ends it early
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (hold_len == '0) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (fall) begin
            state_n = HOLD;
            cnt_n   = '0;
        end else if (state == HOLD) begin
            if (cnt > last || (cnt_ev && cnt == last))
                state_n = IDLE;
            else if (cnt_ev)
                cnt_n = cnt + HOLD_W'(1);
        end
    end
endmodule

// File: rtl/acc_time_ctrl_mc.sv
// acc_time_ctrl_mc: per-channel delay line plus hold stretch; ACC_TIME_CTRL_ANY_EN adds a registered OR output
module acc_time_ctrl_mc
    import acc_pkg::*;
#(
    parameter real TCQ    = 0.1,
    parameter int  CH_NUM = CH_NUM_DEF,
    parameter int  ADDR_W = ADDR_W_DEF,
    parameter int  HOLD_W = HOLD_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              filter_unit_flag_i,
    input  logic [CH_NUM-1:0] filter_acc_result_i,
    input  logic [ADDR_W-1:0] acc_delay_i,
    input  logic [HOLD_W-1:0] acc_hold_i,
    input  logic              hold_unit_mode_i,
    output logic [CH_NUM-1:0] filter_acc_flag_o,
    output logic              filter_acc_any_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [CH_NUM-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] waddr, fill, d, raddr;
    logic [CH_NUM-1:0] dly_q, dly_q_prev, hold_vec;
    logic              cnt_ev;

    assign d        = (acc_delay_i == '0) ? ADDR_W'(1) : acc_delay_i;
    assign raddr    = waddr - d;
    assign cnt_ev   = hold_unit_mode_i ? filter_unit_flag_i : 1'b1;
    assign filter_acc_flag_o = dly_q | hold_vec;

    // delay-line write port, contents survive reset
    always_ff @(posedge clk_i) begin
        if (filter_unit_flag_i)
            mem[waddr] <= filter_acc_result_i;
    end

    // write pointer and saturating fill count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            waddr <= '0;
            fill  <= '0;
        end else if (filter_unit_flag_i) begin
            waddr <= waddr + ADDR_W'(1);
            fill  <= (fill == '1) ? fill : fill + ADDR_W'(1);
        end
    end

    // registered read every cycle, masked until enough samples exist behind the pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dly_q      <= '0;
            dly_q_prev <= '0;
        end else begin
            dly_q      <= (fill < d) ? '0 : mem[raddr];
            dly_q_prev <= dly_q;
        end
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        acc_hold_stretch #(.HOLD_W(HOLD_W)) u_hold (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .fall     (dly_q_prev[c] & ~dly_q[c]),
            .cnt_ev   (cnt_ev),
            .hold_len (acc_hold_i),
            .hold     (hold_vec[c])
        );
    end

`ifdef ACC_TIME_CTRL_ANY_EN
    logic any_q;

    assign filter_acc_any_o = any_q;

    // merged flag, one clock behind the channel flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            any_q <= 1'b0;
        else
            any_q <= |filter_acc_flag_o;
    end
`else
    assign filter_acc_any_o = 1'b0;
`endif
endmodule

// File: tb/tb_acc_time_ctrl_mc.sv
// tb_acc_time_ctrl_mc: directed scenarios against a strobe-history reference model via a scoreboard queue
module tb_acc_time_ctrl_mc;
    typedef struct {
        logic [3:0] flag;
        logic       any;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stb = 1'b0;
    logic        mode = 1'b0;
    logic [3:0]  res = '0;
    logic [7:0]  dly = '0;
    logic [15:0] hold = '0;
    logic [3:0]  flag;
    logic        any;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first0 = -1;
    int hi [4];

    int         n = 0;
    logic [3:0] m_dly = '0;
    logic [3:0] m_prev = '0;
    logic       m_any = 1'b0;
    int         rem [4];
    logic [3:0] hist [4096];
    exp_t       sb [$];

    always #5 clk_i = ~clk_i;

    acc_time_ctrl_mc #(.CH_NUM(4), .ADDR_W(8), .HOLD_W(16)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .filter_unit_flag_i  (stb),
        .filter_acc_result_i (res),
        .acc_delay_i         (dly),
        .acc_hold_i          (hold),
        .hold_unit_mode_i    (mode),
        .filter_acc_flag_o   (flag),
        .filter_acc_any_o    (any)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic clr();
        for (int c = 0; c < 4; c++) hi[c] = 0;
        first0 = -1;
        cyc = 0;
    endtask

    task automatic tick();
        exp_t       e;
        int         dd, f;
        int         rn [4];
        logic [3:0] nd, hv;
        if (rst_i) begin
            n = 0;
            m_dly = '0;
            m_prev = '0;
            m_any = 1'b0;
            for (int c = 0; c < 4; c++) rem[c] = 0;
        end else begin
            dd = (dly == 0) ? 1 : int'(dly);
            f = (n > 255) ? 255 : n;
            nd = (f >= dd) ? hist[n - dd] : 4'b0;
            for (int c = 0; c < 4; c++) begin
                hv[c] = rem[c] > 0;
                if (hold == 0) rn[c] = 0;
                else if (m_prev[c] && !m_dly[c]) rn[c] = int'(hold);
                else if (rem[c] > 0 && (mode ? stb : 1'b1)) rn[c] = rem[c] - 1;
                else rn[c] = rem[c];
            end
            m_any = |(m_dly | hv);
            if (stb) begin
                hist[n] = res;
                n++;
            end
            m_prev = m_dly;
            m_dly = nd;
            rem = rn;
        end
        for (int c = 0; c < 4; c++) hv[c] = rem[c] > 0;
        e.flag = m_dly | hv;
`ifdef ACC_TIME_CTRL_ANY_EN
        e.any = m_any;
`else
        e.any = 1'b0;
`endif
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        cyc++;
        e = sb.pop_front();
        check("flag", 32'(flag), 32'(e.flag));
        check("any", 32'(any), 32'(e.any));
        for (int c = 0; c < 4; c++) hi[c] += int'(flag[c]);
        if (flag[0] && first0 < 0) first0 = cyc;
    endtask

    task automatic unit(input logic [3:0] r);
        res = r;
        stb = 1'b1;
        tick();
        stb = 1'b0;
        res = '0;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        check("rst_flag", 32'(flag), 32'h0);
        check("rst_any", 32'(any), 32'h0);
        tick();
        tick();
        rst_i = 1'b0;
        clr();
    endtask

    initial begin
        @(posedge clk_i);
        #1;
        dly = 8'd5; hold = 16'd0; mode = 1'b0;
        do_reset();
        unit(4'b0001);
        repeat (7) unit(4'b0000);
        check("d5_latency", first0, 18);
        check("d5_width", hi[0], 4);
        check("d5_others", hi[1] + hi[2] + hi[3], 0);

        dly = 8'd0;
        do_reset();
        repeat (3) unit(4'b0001);
        repeat (3) unit(4'b0000);
        check("d0_width", hi[0], 12);

        dly = 8'd3; hold = 16'd10;
        do_reset();
        unit(4'b0100);
        repeat (8) unit(4'b0000);
        check("hold_clk_width", hi[2], 14);
        clr();
        unit(4'b0100);
        unit(4'b0000);
        unit(4'b0100);
        repeat (8) unit(4'b0000);
        check("hold_retrigger_width", hi[2], 22);

        hold = 16'd3; mode = 1'b1;
        do_reset();
        unit(4'b0010);
        repeat (6) unit(4'b0000);
        check("hold_strobe_width", hi[1], 14);

        dly = 8'd255; hold = 16'd0; mode = 1'b0;
        do_reset();
        repeat (300) unit(4'($urandom_range(0, 15)));

        dly = 8'd2; hold = 16'd10;
        do_reset();
        unit(4'b1000);
        repeat (3) unit(4'b0000);
        check("pre_reset_hold", 32'(flag[3]), 32'h1);
        do_reset();
        repeat (4) unit(4'b0000);
        check("post_reset_quiet", hi[3], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
